// File: rtl/can_pkg.sv
// Shared CAN receive-path definitions: destuffer state encoding and frame constants
// common to the destuffer and the CRC stage.
package can_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    RUN          = 2'd1,
    EXPECT_STUFF = 2'd2,
    ERROR        = 2'd3
  } can_destuff_state_t;

  localparam int CAN_STUFF_LEN = 5;
  localparam int CAN_CRC_W     = 15;

endpackage

// File: rtl/can_bit_destuffer.sv
// CAN receive bit destuffer: removes the complementary bit inserted after a run of
// STUFF_LEN equal bits, flags stuff violations and feeds the CRC stage one bit per pulse.
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             bit_strobe,
  input  logic             rx_bit,
  input  logic             stuff_en,
  input  logic             clear,
  output logic             data_out,
  output logic             data_valid,
  output logic             stuff_drop,
  output logic             stuff_err,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int               RUN_W   = $clog2(STUFF_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  can_destuff_state_t state, state_nxt;
  logic [RUN_W-1:0]   run_len, run_len_nxt, run_len_inc;
  logic               prev_bit, prev_bit_nxt;
  logic               data_out_nxt;
  logic               data_valid_nxt;
  logic               stuff_drop_nxt;
  logic               stuff_err_nxt;
  logic [CNT_W-1:0]   bit_cnt_nxt;
  logic               deliver;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      run_len    <= '0;
      prev_bit   <= 1'b1;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      stuff_drop <= 1'b0;
      stuff_err  <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      run_len    <= run_len_nxt;
      prev_bit   <= prev_bit_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      stuff_drop <= stuff_drop_nxt;
      stuff_err  <= stuff_err_nxt;
      bit_cnt    <= bit_cnt_nxt;
    end
  end

  // Outside the stuffing window every non-error strobe is a plain pass-through bit
  // and any pending stuff expectation is dropped.
  always_comb begin
    state_nxt      = state;
    run_len_nxt    = run_len;
    prev_bit_nxt   = prev_bit;
    data_out_nxt   = data_out;
    data_valid_nxt = 1'b0;
    stuff_drop_nxt = 1'b0;
    stuff_err_nxt  = stuff_err;
    bit_cnt_nxt    = bit_cnt;
    deliver        = 1'b0;
    run_len_inc    = (rx_bit == prev_bit) ? run_len + RUN_ONE : RUN_ONE;

    if (clear) begin
      state_nxt     = IDLE;
      run_len_nxt   = '0;
      prev_bit_nxt  = 1'b1;
      stuff_err_nxt = 1'b0;
      bit_cnt_nxt   = '0;
    end else if (bit_strobe && state != ERROR) begin
      if (!stuff_en) begin
        deliver     = 1'b1;
        state_nxt   = IDLE;
        run_len_nxt = '0;
      end else begin
        case (state)
          IDLE: begin
            deliver      = 1'b1;
            prev_bit_nxt = rx_bit;
            run_len_nxt  = RUN_ONE;
            state_nxt    = RUN;
          end
          RUN: begin
            deliver      = 1'b1;
            prev_bit_nxt = rx_bit;
            run_len_nxt  = run_len_inc;
            if (run_len_inc == RUN_MAX) begin
              state_nxt = EXPECT_STUFF;
            end
          end
          EXPECT_STUFF: begin
            // The removed stuff bit is the first bit of the next run.
            if (rx_bit != prev_bit) begin
              stuff_drop_nxt = 1'b1;
              prev_bit_nxt   = rx_bit;
              run_len_nxt    = RUN_ONE;
              state_nxt      = RUN;
            end else begin
              stuff_err_nxt = 1'b1;
              state_nxt     = ERROR;
            end
          end
          default: begin
          end
        endcase
      end
    end

    if (deliver) begin
      data_out_nxt   = rx_bit;
      data_valid_nxt = 1'b1;
      if (bit_cnt != CNT_MAX) begin
        bit_cnt_nxt = bit_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Randomized self-checking bench for can_bit_destuffer against a bit-history model
// of the CAN stuffing rule.
module tb_can_bit_destuffer;
  import can_pkg::*;

  localparam int STUFF   = 5;
  localparam int CNT_MAX = 255;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       bit_strobe = 1'b0;
  logic       rx_bit = 1'b0;
  logic       stuff_en = 1'b0;
  logic       clear = 1'b0;
  logic       data_out;
  logic       data_valid;
  logic       stuff_drop;
  logic       stuff_err;
  logic [7:0] bit_cnt;

  can_bit_destuffer #(.STUFF_LEN(STUFF), .CNT_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .bit_strobe(bit_strobe), .rx_bit(rx_bit),
    .stuff_en(stuff_en), .clear(clear), .data_out(data_out), .data_valid(data_valid),
    .stuff_drop(stuff_drop), .stuff_err(stuff_err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: bits seen in the current stuffing window (data and stuff bits).
  logic hist[$];
  logic exp_dv, exp_drop, exp_err, exp_dout;
  int   exp_cnt;

  logic obs_dv, obs_drop, obs_err, obs_dout, obs_pulse2;
  int   obs_cnt;

  function automatic void model_reset(input logic keep_dout);
    hist.delete();
    exp_dv = 1'b0; exp_drop = 1'b0; exp_err = 1'b0; exp_cnt = 0;
    if (!keep_dout) exp_dout = 1'b0;
  endfunction

  function automatic logic stuff_due();
    if (hist.size() < STUFF) return 1'b0;
    for (int i = 1; i <= STUFF; i++)
      if (hist[hist.size()-i] != hist[hist.size()-1]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_deliver(input logic b);
    exp_dv = 1'b1; exp_dout = b;
    if (exp_cnt < CNT_MAX) exp_cnt++;
  endfunction

  function automatic void model_step(input logic b, input logic en);
    exp_dv = 1'b0; exp_drop = 1'b0;
    if (exp_err) return;
    if (!en) begin
      model_deliver(b);
      hist.delete();
    end else if (stuff_due()) begin
      if (b != hist[hist.size()-1]) begin
        exp_drop = 1'b1;
        hist.push_back(b);
      end else begin
        exp_err = 1'b1;
      end
    end else begin
      model_deliver(b);
      hist.push_back(b);
    end
    if (hist.size() > STUFF) void'(hist.pop_front());
  endfunction

  task automatic strobe_bit(input logic b, input logic en);
    @(negedge clk);
    bit_strobe = 1'b1; rx_bit = b; stuff_en = en;
    model_step(b, en);
    @(negedge clk);
    bit_strobe = 1'b0;
    obs_dv = data_valid; obs_drop = stuff_drop; obs_err = stuff_err;
    obs_dout = data_out; obs_cnt = int'(bit_cnt);
    @(negedge clk);
    obs_pulse2 = data_valid | stuff_drop;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    model_reset(1'b1);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    model_reset(1'b0);
    n_checks++; if ({data_out, data_valid, stuff_drop, stuff_err} !== 4'b0000) $display("[TB] FAIL reset_flags got %b want 0000", {data_out, data_valid, stuff_drop, stuff_err}); else n_pass++;
    n_checks++; if (bit_cnt !== 8'd0) $display("[TB] FAIL reset_cnt got %0d want 0", bit_cnt); else n_pass++;
    n_checks++; if (dut.state !== IDLE) $display("[TB] FAIL reset_state got %0d want IDLE", dut.state); else n_pass++;
    n_checks++; if (dut.prev_bit !== 1'b1) $display("[TB] FAIL reset_prev got %b want 1", dut.prev_bit); else n_pass++;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic run_pattern(input string name, input logic [15:0] bits, input int len, input logic en);
    for (int i = 0; i < len; i++) begin
      strobe_bit(bits[len-1-i], en);
      n_checks++; if (obs_dv !== exp_dv) $display("[TB] FAIL %s_dv[%0d] got %b want %b", name, i, obs_dv, exp_dv); else n_pass++;
      n_checks++; if (obs_drop !== exp_drop) $display("[TB] FAIL %s_drop[%0d] got %b want %b", name, i, obs_drop, exp_drop); else n_pass++;
      n_checks++; if (obs_err !== exp_err) $display("[TB] FAIL %s_err[%0d] got %b want %b", name, i, obs_err, exp_err); else n_pass++;
      n_checks++; if (obs_cnt !== exp_cnt) $display("[TB] FAIL %s_cnt[%0d] got %0d want %0d", name, i, obs_cnt, exp_cnt); else n_pass++;
      if (exp_dv) begin
        n_checks++; if (obs_dout !== exp_dout) $display("[TB] FAIL %s_dout[%0d] got %b want %b", name, i, obs_dout, exp_dout); else n_pass++;
      end
      n_checks++; if (obs_pulse2 !== 1'b0) $display("[TB] FAIL %s_pulse_width[%0d] got %b want 0", name, i, obs_pulse2); else n_pass++;
    end
  endtask

  task automatic test_no_stuff();
    do_clear();
    run_pattern("nostuff", 16'b010110, 6, 1'b1);
    n_checks++; if (bit_cnt !== 8'd6) $display("[TB] FAIL nostuff_total got %0d want 6", bit_cnt); else n_pass++;
  endtask

  task automatic test_stuff_drop();
    do_clear();
    run_pattern("drop", 16'b0000010, 7, 1'b1);
    n_checks++; if (bit_cnt !== 8'd6) $display("[TB] FAIL drop_total got %0d want 6", bit_cnt); else n_pass++;
    n_checks++; if (dut.run_len !== 3'd1) $display("[TB] FAIL drop_run_len got %0d want 1", dut.run_len); else n_pass++;
  endtask

  task automatic test_stuff_error();
    do_clear();
    run_pattern("err", 16'b111111, 6, 1'b1);
    n_checks++; if (dut.state !== ERROR) $display("[TB] FAIL err_state got %0d want ERROR", dut.state); else n_pass++;
    run_pattern("err_ignore", 16'b0101, 4, 1'b1);
    run_pattern("err_ignore_noen", 16'b01, 2, 1'b0);
    do_clear();
    n_checks++; if (stuff_err !== 1'b0) $display("[TB] FAIL err_clear got %b want 0", stuff_err); else n_pass++;
    n_checks++; if (bit_cnt !== 8'd0) $display("[TB] FAIL err_clear_cnt got %0d want 0", bit_cnt); else n_pass++;
  endtask

  task automatic test_stuff_in_run();
    do_clear();
    run_pattern("stuffrun", 16'b0000011111, 10, 1'b1);
    run_pattern("stuffrun_err", 16'b1, 1, 1'b1);
    n_checks++; if (stuff_err !== 1'b1) $display("[TB] FAIL stuffrun_final got %b want 1", stuff_err); else n_pass++;
  endtask

  task automatic test_passthrough();
    do_clear();
    run_pattern("pass", 16'b0000000, 7, 1'b0);
    n_checks++; if (dut.state !== IDLE) $display("[TB] FAIL pass_state got %0d want IDLE", dut.state); else n_pass++;
    run_pattern("pass_abort", 16'b00000, 5, 1'b1);
    run_pattern("pass_abort_off", 16'b0, 1, 1'b0);
    run_pattern("pass_abort_new", 16'b0, 1, 1'b1);
  endtask

  task automatic test_clear_priority();
    do_clear();
    run_pattern("clrpri", 16'b0011, 4, 1'b1);
    @(negedge clk);
    clear = 1'b1; bit_strobe = 1'b1; rx_bit = 1'b1; stuff_en = 1'b1;
    model_reset(1'b1);
    @(negedge clk);
    clear = 1'b0; bit_strobe = 1'b0;
    n_checks++; if (data_valid !== 1'b0) $display("[TB] FAIL clrpri_dv got %b want 0", data_valid); else n_pass++;
    n_checks++; if (bit_cnt !== 8'd0) $display("[TB] FAIL clrpri_cnt got %0d want 0", bit_cnt); else n_pass++;
    n_checks++; if (data_out !== exp_dout) $display("[TB] FAIL clrpri_dout_hold got %b want %b", data_out, exp_dout); else n_pass++;
    run_pattern("clrpri_after", 16'b11111, 5, 1'b1);
  endtask

  task automatic test_async_reset();
    do_clear();
    run_pattern("arst_pre", 16'b111, 3, 1'b1);
    @(negedge clk);
    bit_strobe = 1'b1; rx_bit = 1'b1; stuff_en = 1'b1;
    @(posedge clk);
    #1 bit_strobe = 1'b0;
    #1 n_rst = 1'b0;
    model_reset(1'b0);
    #1;
    n_checks++; if ({data_out, data_valid, stuff_drop, stuff_err} !== 4'b0000) $display("[TB] FAIL arst_flags got %b want 0000", {data_out, data_valid, stuff_drop, stuff_err}); else n_pass++;
    n_checks++; if (bit_cnt !== 8'd0) $display("[TB] FAIL arst_cnt got %0d want 0", bit_cnt); else n_pass++;
    @(negedge clk);
    n_checks++; if (data_valid !== 1'b0) $display("[TB] FAIL arst_no_pulse got %b want 0", data_valid); else n_pass++;
    n_rst = 1'b1;
    run_pattern("arst_post", 16'b11111, 5, 1'b1);
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 0; i < CNT_MAX + 4; i++) strobe_bit(1'($urandom_range(0, 1)), 1'b0);
    n_checks++; if (obs_cnt !== CNT_MAX) $display("[TB] FAIL sat_cnt got %0d want %0d", obs_cnt, CNT_MAX); else n_pass++;
    n_checks++; if (obs_dv !== 1'b1) $display("[TB] FAIL sat_dv got %b want 1", obs_dv); else n_pass++;
  endtask

  task automatic test_random();
    logic b = 1'b0;
    logic en;
    do_clear();
    for (int i = 0; i < 600; i++) begin
      if (exp_err && $urandom_range(0, 3) == 0) do_clear();
      if ($urandom_range(0, 9) < 3) b = ~b;
      en = ($urandom_range(0, 19) != 0);
      strobe_bit(b, en);
      n_checks++; if ({obs_dv, obs_drop, obs_err} !== {exp_dv, exp_drop, exp_err}) $display("[TB] FAIL rand_flags[%0d] got %b want %b", i, {obs_dv, obs_drop, obs_err}, {exp_dv, exp_drop, exp_err}); else n_pass++;
      n_checks++; if (obs_cnt !== exp_cnt) $display("[TB] FAIL rand_cnt[%0d] got %0d want %0d", i, obs_cnt, exp_cnt); else n_pass++;
      n_checks++; if (obs_dout !== exp_dout) $display("[TB] FAIL rand_dout[%0d] got %b want %b", i, obs_dout, exp_dout); else n_pass++;
    end
  endtask

  initial begin
    model_reset(1'b0);
    test_reset();
    test_no_stuff();
    test_stuff_drop();
    test_stuff_error();
    test_stuff_in_run();
    test_passthrough();
    test_clear_priority();
    test_async_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/can_bit_destuffer.md
Name: can_bit_destuffer

Overview:
- Receive-path stage that sits directly upstream of the CAN CRC engine.
- Takes one sampled bus bit per sample-point strobe and removes stuff bits inserted after STUFF_LEN consecutive equal bits.
- Detects stuff-rule violations.
- Delivers destuffed data bits with a one-cycle valid pulse; data_out/data_valid drive the CRC block's data/crc_en directly.

Parameters:
- STUFF_LEN, 5: run length of equal bits after which a complementary stuff bit is expected.
- CNT_W, 8: width of the destuffed-bit counter.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous, active-low reset
- bit_strobe  input  1  one-cycle pulse at bit sample point; rx_bit valid in that cycle
- rx_bit  input  1  sampled bus value (0 = dominant)
- stuff_en  input  1  stuffing window (SOF through CRC sequence incl. trailing stuff bit); sampled only with bit_strobe
- clear  input  1  synchronous restart (frame start / bus idle / error handling)
- data_out  output  1  destuffed bit
- data_valid  output  1  one-cycle pulse, data_out valid
- stuff_drop  output  1  one-cycle pulse, a stuff bit was removed
- stuff_err  output  1  sticky stuff-error flag
- bit_cnt  output  CNT_W  destuffed bits delivered since last clear

Behaviour:
- Reset values (n_rst low, async): data_out=0, data_valid=0, stuff_drop=0, stuff_err=0, bit_cnt=0, run_len=0, prev_bit=1, state=IDLE.
- All outputs are registered. Latency is 1 clk: a strobe in cycle N produces outputs in cycle N+1. Pulse outputs are high for exactly one clk.
- clear has priority over bit_strobe in the same cycle. clear returns to the reset values except data_out, which holds its value.
- States: IDLE, RUN, EXPECT_STUFF, ERROR. Evaluation happens only in cycles with bit_strobe=1.
- IDLE, stuff_en=1:
  - deliver rx_bit (data_valid);
  - prev_bit<=rx_bit, run_len<=1;
  - go to RUN.
- IDLE, stuff_en=0: deliver rx_bit as pass-through; stay IDLE; run_len stays 0.
- RUN, stuff_en=1:
  - deliver rx_bit;
  - if rx_bit==prev_bit, run_len+1; otherwise run_len<=1;
  - prev_bit<=rx_bit;
  - if the new run_len==STUFF_LEN, go to EXPECT_STUFF.
- EXPECT_STUFF, rx_bit!=prev_bit:
  - no data_valid; stuff_drop pulse;
  - prev_bit<=rx_bit, run_len<=1 (the stuff bit starts the new run);
  - go to RUN.
- EXPECT_STUFF, rx_bit==prev_bit:
  - no data_valid; stuff_err<=1;
  - go to ERROR.
- Any non-ERROR state, stuff_en=0 at strobe: pass-through delivery; state<=IDLE, run_len<=0. A pending stuff expectation is discarded. The frame controller holds stuff_en high through the trailing stuff bit.
- ERROR: ignore strobes; no data_valid, no stuff_drop; stuff_err stays high. Only clear or n_rst exits ERROR.
- bit_cnt increments on every data_valid and saturates at 2^CNT_W-1. It never counts stuff bits.
- run_len width is $clog2(STUFF_LEN+1). run_len never exceeds STUFF_LEN.
- bit_strobe is never asserted in consecutive cycles; the block does not need to handle back-to-back strobes.
- n_rst mid-frame aborts immediately; no partial output pulse follows.

Decomposition:
- Shared package can_pkg holds:
  - the enum type can_destuff_state_t {IDLE, RUN, EXPECT_STUFF, ERROR};
  - the constant CAN_STUFF_LEN=5;
  - the constant CAN_CRC_W=15, shared with the CRC stage.
- Single module; no sub-module is needed. The run-length counter is inline.

Test Plan:
- Strobe bits 0,1,0,1,1,0 with stuff_en=1 -> six data_valid pulses with the same bits, each 1 clk after its strobe; bit_cnt=6; no stuff_drop.
- Strobe 0,0,0,0,0,1,0 with stuff_en=1 -> data_valid for the five 0s; stuff_drop (not data_valid) on the 1; the final 0 is delivered; bit_cnt=6; run_len=1 after the final bit.
- Strobe 1,1,1,1,1,1 with stuff_en=1 -> five deliveries, then stuff_err=1 and state ERROR; further strobes give no data_valid until clear; clear -> stuff_err=0, bit_cnt=0.
- Strobe 0,0,0,0,0 (stuff_en=1), drop stuff bit 1, then strobe 1,1,1,1 -> stuff bit counts in the run; the 4th following 1 completes a run of 5 and the next equal 1 raises stuff_err.
- stuff_en=0 with seven 0s -> all seven pass through; no stuff_drop, no stuff_err; state stays IDLE.
- clear and bit_strobe in the same cycle mid-run -> clear wins; no data_valid; bit_cnt=0. Also: assert n_rst low between strobes -> all outputs 0 asynchronously.
